// File: rtl/mult_pkg.sv
// Shared widths and default timing for the multiplier stream controller.
package mult_pkg;
    localparam int OP_W        = 6;
    localparam int PROD_W      = 12;
    localparam int MUL_LAT_DEF = 3;
    localparam int DEPTH_DEF   = 4;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mult_stream_ctrl.sv
// Credit-based issue controller for an external pipelined multiplier: tracks
// products in flight and buffers them in a FIFO so the consumer can stall.
module mult_stream_ctrl
    import mult_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_a,
    input  logic [OP_W-1:0]          in_b,
    output logic [OP_W-1:0]          mul_a,
    output logic [OP_W-1:0]          mul_b,
    input  logic [PROD_W-1:0]        mul_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PROD_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   inflight
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    logic [MUL_LAT-1:0] vld_pipe;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credits;
    logic [PROD_W-1:0]  fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fire_in;
    logic               fire_out;
    logic               capture;

    // Credits come only from registered counts, so a pop frees its slot one
    // cycle late and there is no path from out_ready/in_valid to in_ready.
    assign credits  = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready = !rst && !fifo_full && (credits < CREDIT_MAX);
    assign fire_in  = in_valid && in_ready;
    assign mul_a    = fire_in ? in_a : '0;
    assign mul_b    = fire_in ? in_b : '0;
    assign capture  = vld_pipe[MUL_LAT-1];

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata;
    assign fire_out  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            inflight <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | MUL_LAT'(fire_in);
            unique case ({fire_in, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (PROD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (fire_out),
        .wdata (mul_result),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Scoreboard bench: a timed product queue predicts in_ready, out_valid,
// out_data and inflight each cycle; a second instance checks streaming.
module tb_mult_stream_ctrl;
    localparam int MUL_LAT = 3;
    localparam int DEPTH   = 4;
    localparam int S_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_a, in_b, mul_a, mul_b;
    logic [11:0] mul_result, out_data;
    logic [2:0]  inflight;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [5:0]  s_in_a, s_in_b, s_mul_a, s_mul_b;
    logic [11:0] s_mul_result, s_out_data;
    logic [3:0]  s_inflight;

    mult_stream_ctrl #(.MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .inflight(inflight));

    mult_stream_ctrl #(.MUL_LAT(MUL_LAT), .DEPTH(S_DEPTH)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .mul_a(s_mul_a), .mul_b(s_mul_b),
        .mul_result(s_mul_result), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .inflight(s_inflight));

    // Behavioural multiplier with MUL_LAT register stages
    logic [11:0] mpipe [MUL_LAT];
    logic [11:0] s_mpipe [MUL_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mpipe[i]   <= '0;
                s_mpipe[i] <= '0;
            end
        end else begin
            mpipe[0]   <= 12'(mul_a) * 12'(mul_b);
            s_mpipe[0] <= 12'(s_mul_a) * 12'(s_mul_b);
            for (int i = 1; i < MUL_LAT; i++) begin
                mpipe[i]   <= mpipe[i-1];
                s_mpipe[i] <= s_mpipe[i-1];
            end
        end
    end
    assign mul_result   = mpipe[MUL_LAT-1];
    assign s_mul_result = s_mpipe[MUL_LAT-1];

    typedef struct { int p; int rdy; } exp_t;
    exp_t q[$];
    int cyc = 0, issued = 0, popped = 0, total = 0, bad = 0;
    int s_fire[$], s_exp[$], s_got[$], s_gcyc[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: expected state is taken from the queue before this cycle's events.
    always @(negedge clk) begin
        int  n;
        bit  ev;
        if (rst) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_mul_a", int'(mul_a), 0);
            q.delete();
            issued = 0;
            popped = 0;
        end else begin
            chk("in_ready", int'(in_ready), int'((issued - popped) < DEPTH));
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("out_valid", int'(out_valid), int'(ev));
            if (ev) chk("out_data", int'(out_data), q[0].p);
            n = 0;
            foreach (q[i]) if (q[i].rdy > cyc) n++;
            chk("inflight", int'(inflight), n);
            if (ev && out_ready) begin
                void'(q.pop_front());
                popped++;
            end
            if (in_valid && in_ready) begin
                chk("mul_a", int'(mul_a), int'(in_a));
                q.push_back('{int'(in_a) * int'(in_b), cyc + MUL_LAT + 1});
                issued++;
            end
            if (s_in_valid && s_in_ready) begin
                s_fire.push_back(cyc);
                s_exp.push_back(int'(s_in_a) * int'(s_in_b));
            end
            if (s_out_valid && s_out_ready) begin
                s_got.push_back(int'(s_out_data));
                s_gcyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b);
        bit ok = 0;
        in_a = 6'(a);
        in_b = 6'(b);
        in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: got no in_ready want in_ready for %0dx%0d", a, b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
        s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_out_ready = 1;
        rst = 1;
        idle(3);
        rst = 0;

        send(5, 7);   idle(6);
        send(63, 63); send(0, 45); idle(6);

        // Backpressure: four credits, fifth pair held until the consumer resumes
        out_ready = 0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send(k, k);
            end
            begin
                idle(14);
                out_ready = 1;
            end
        join
        idle(8);

        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 6'($urandom_range(0, 63));
            in_b      = 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        idle(10);

        // Reset with one stored product and two in flight
        out_ready = 0;
        send(9, 9); idle(2);
        send(2, 3); send(4, 5);
        chk("pre_rst_inflight", int'(inflight), 2);
        chk("pre_rst_out_valid", int'(out_valid), 1);
        rst = 1;
        idle(1);
        rst = 0;
        chk("post_rst_inflight", int'(inflight), 0);
        chk("post_rst_out_valid", int'(out_valid), 0);
        out_ready = 1;
        idle(8);

        // Streaming on the deeper instance
        for (int i = 0; i < 16; i++) begin
            s_in_a = 6'($urandom_range(0, 63));
            s_in_b = 6'($urandom_range(0, 63));
            s_in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", int'(s_in_ready), 1);
            @(posedge clk); #1;
        end
        s_in_valid = 0;
        idle(10);
        chk("stream_count", s_got.size(), 16);
        for (int i = 0; i < 16 && i < s_got.size() && i < s_exp.size(); i++) begin
            chk("stream_data", s_got[i], s_exp[i]);
            chk("stream_cycle", s_gcyc[i], s_fire[0] + MUL_LAT + 1 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
